vip_axi4_sink_slave: RTL

VIP_AXI4_SINK_SLAVE -- requirements
Module: vip_axi4_sink_slave

---
 rtl/vip_axi4_sink_slave.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/vip_axi4_sink_slave.sv
// AXI4 sink slave: accepts any write or read burst and answers with a fixed response code and fill data.
// Optional VIP_AXI4_SINK_SLAVE_STATS_EN adds wr_count/rd_count completion counters.
module vip_axi4_sink_slave #(
  parameter int unsigned ID_WIDTH_P   = 4,
  parameter int unsigned ADDR_WIDTH_P = 32,
  parameter int unsigned DATA_WIDTH_P = 32,
  parameter int unsigned USER_WIDTH_P = 1,
  parameter logic [1:0]  RESP_P       = 2'b11,
  parameter logic [DATA_WIDTH_P-1:0] FILL_P = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH_P-1:0]     awid,
  input  logic [ADDR_WIDTH_P-1:0]   awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awlock,
  input  logic [3:0]                awcache,
  input  logic [2:0]                awprot,
  input  logic [3:0]                awqos,
  input  logic [3:0]                awregion,
  input  logic [USER_WIDTH_P-1:0]   awuser,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH_P-1:0]   wdata,
  input  logic [DATA_WIDTH_P/8-1:0] wstrb,
  input  logic                      wlast,
  input  logic [USER_WIDTH_P-1:0]   wuser,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_WIDTH_P-1:0]     bid,
  output logic [1:0]                bresp,
  output logic [USER_WIDTH_P-1:0]   buser,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ID_WIDTH_P-1:0]     arid,
  input  logic [ADDR_WIDTH_P-1:0]   araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      arlock,
  input  logic [3:0]                arcache,
  input  logic [2:0]                arprot,
  input  logic [3:0]                arqos,
  input  logic [3:0]                arregion,
  input  logic [USER_WIDTH_P-1:0]   aruser,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [ID_WIDTH_P-1:0]     rid,
  output logic [DATA_WIDTH_P-1:0]   rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic [USER_WIDTH_P-1:0]   ruser,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      err_wlast
`ifdef VIP_AXI4_SINK_SLAVE_STATS_EN
  ,
  output logic [31:0]               wr_count,
  output logic [31:0]               rd_count
`endif
);

  localparam int unsigned LEN_W = 8;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [1:0]            w_state, w_state_nxt;
  logic [LEN_W-1:0]      w_cnt, w_cnt_nxt, w_len, w_len_nxt;
  logic [ID_WIDTH_P-1:0] w_id_nxt;
  logic                  err_nxt;

  logic [0:0]            r_state, r_state_nxt;
  logic [LEN_W-1:0]      r_cnt, r_cnt_nxt, r_len, r_len_nxt;
  logic [ID_WIDTH_P-1:0] r_id_nxt;
  logic                  rlast_nxt;

  // Payload fields the sink never looks at.
  logic unused_inputs;
  assign unused_inputs = ^{awaddr, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
                           awuser, wdata, wstrb, wuser, araddr, arsize, arburst, arlock,
                           arcache, arprot, arqos, arregion, aruser};

  assign bresp = RESP_P;
  assign buser = '0;
  assign rresp = RESP_P;
  assign ruser = '0;
  assign rdata = FILL_P;

  // Write path next state: the final beat is decided by the beat count, wlast only feeds the error flag.
  always_comb begin
    w_state_nxt = w_state;
    w_cnt_nxt   = w_cnt;
    w_len_nxt   = w_len;
    w_id_nxt    = bid;
    err_nxt     = err_wlast;
    case (w_state)
      W_IDLE: begin
        if (awvalid && awready) begin
          w_state_nxt = W_DATA;
          w_id_nxt    = awid;
          w_len_nxt   = awlen;
          w_cnt_nxt   = '0;
        end
      end
      W_DATA: begin
        if (wvalid && wready) begin
          if (w_cnt == w_len) begin
            w_state_nxt = W_RESP;
            if (!wlast) err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt + LEN_W'(1);
            if (wlast) err_nxt = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (bvalid && bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      w_cnt     <= '0;
      w_len     <= '0;
      bid       <= '0;
      err_wlast <= 1'b0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
    end else begin
      w_state   <= w_state_nxt;
      w_cnt     <= w_cnt_nxt;
      w_len     <= w_len_nxt;
      bid       <= w_id_nxt;
      err_wlast <= err_nxt;
      awready   <= (w_state_nxt == W_IDLE);
      wready    <= (w_state_nxt == W_DATA);
      bvalid    <= (w_state_nxt == W_RESP);
    end
  end

  // Read path next state; rlast is precomputed for the beat about to be presented.
  always_comb begin
    r_state_nxt = r_state;
    r_cnt_nxt   = r_cnt;
    r_len_nxt   = r_len;
    r_id_nxt    = rid;
    rlast_nxt   = rlast;
    case (r_state)
      R_IDLE: begin
        if (arvalid && arready) begin
          r_state_nxt = R_DATA;
          r_id_nxt    = arid;
          r_len_nxt   = arlen;
          r_cnt_nxt   = '0;
          rlast_nxt   = (arlen == LEN_W'(0));
        end
      end
      R_DATA: begin
        if (rvalid && rready) begin
          if (r_cnt == r_len) begin
            r_state_nxt = R_IDLE;
            rlast_nxt   = 1'b0;
          end else begin
            r_cnt_nxt = r_cnt + LEN_W'(1);
            rlast_nxt = ((r_cnt + LEN_W'(1)) == r_len);
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      rid     <= '0;
      rlast   <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      r_cnt   <= r_cnt_nxt;
      r_len   <= r_len_nxt;
      rid     <= r_id_nxt;
      rlast   <= rlast_nxt;
      arready <= (r_state_nxt == R_IDLE);
      rvalid  <= (r_state_nxt == R_DATA);
    end
  end

`ifdef VIP_AXI4_SINK_SLAVE_STATS_EN
  // Completed-transaction counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (bvalid && bready)          wr_count <= wr_count + 32'd1;
      if (rvalid && rready && rlast) rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule
